// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - gshare-style 2-bit branch direction predictor with speculative global history
module branch_history_table #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    input  logic             lookup_is_br,
    input  logic             stall,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [IDX_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispred
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt [DEPTH];
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [1:0]       up_cnt;
    logic [1:0]       up_next;
    logic             pred_bit;
    logic             mispred;
    logic             unused_pc_bits;

    assign lk_idx   = lookup_pc[IDX_W+1:2] ^ ghr;
    assign up_idx   = upd_pc[IDX_W+1:2] ^ upd_ghr;
    assign pred_bit = lookup_is_br & cnt[lk_idx][1];
    assign mispred  = upd_valid & upd_mispred;
    assign up_cnt   = cnt[up_idx];

    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    always_comb begin
        up_next = up_cnt;
        if (upd_taken && up_cnt != 2'b11)
            up_next = up_cnt + 2'd1;
        else if (!upd_taken && up_cnt != 2'b00)
            up_next = up_cnt - 2'd1;
    end

    // Lookup reads the pre-edge table, so a same-cycle update is seen only from the next lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= 2'b01;
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ghr   <= '0;
        end else begin
            if (upd_valid)
                cnt[up_idx] <= up_next;

            // A resolved mispredict repairs history and squashes whatever fetch presented.
            if (mispred) begin
                ghr        <= {upd_ghr[IDX_W-2:0], upd_taken};
                pred_valid <= 1'b0;
            end else if (!stall) begin
                pred_valid <= lookup_valid;
                if (lookup_valid) begin
                    pred_taken <= pred_bit;
                    pred_ghr   <= ghr;
                    if (lookup_is_br)
                        ghr <= {ghr[IDX_W-2:0], pred_bit};
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - randomized and directed checks of branch_history_table against a reference model
module tb_branch_history_table;
    localparam int IDX_W = 6;
    localparam int PC_W  = 32;
    localparam int DEPTH = 64;
    localparam int MASK  = 63;

    logic             clk;
    logic             reset_n;
    logic             lookup_valid;
    logic [PC_W-1:0]  lookup_pc;
    logic             lookup_is_br;
    logic             stall;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [IDX_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispred;

    int vectors;
    int miscompares;

    int m_cnt [DEPTH];
    int m_ghr;
    int m_pv;
    int m_pt;
    int m_pg;

    branch_history_table #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_is_br(lookup_is_br),
        .stall(stall),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_out();
        logic [7:0] v;
        v[7]   = (m_pv != 0);
        v[6]   = (m_pt != 0);
        v[5:0] = 6'(m_pg);
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pred_valid, pred_taken, pred_ghr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
        m_ghr = 0; m_pv = 0; m_pt = 0; m_pg = 0;
    endtask

    task automatic idle_inputs();
        lookup_valid = 0; lookup_pc = '0; lookup_is_br = 0; stall = 0;
        upd_valid = 0; upd_pc = '0; upd_ghr = '0; upd_taken = 0; upd_mispred = 0;
    endtask

    // One clock: model consumes the inputs presented now, then returns at the next falling edge.
    task automatic tick();
        int lk, ub, pbit;
        bit mis;
        lk   = (int'(lookup_pc >> 2) ^ m_ghr) & MASK;
        ub   = (int'(upd_pc >> 2) ^ int'(upd_ghr)) & MASK;
        pbit = (lookup_is_br && m_cnt[lk] >= 2) ? 1 : 0;
        mis  = upd_valid && upd_mispred;
        @(posedge clk);
        if (reset_n) begin
            if (mis) begin
                m_pv  = 0;
                m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & MASK;
            end else if (!stall) begin
                m_pv = lookup_valid;
                if (lookup_valid) begin
                    m_pt = pbit;
                    m_pg = m_ghr;
                    if (lookup_is_br) m_ghr = ((m_ghr << 1) | pbit) & MASK;
                end
            end
            if (upd_valid)
                m_cnt[ub] = upd_taken ? ((m_cnt[ub] < 3) ? m_cnt[ub] + 1 : 3)
                                      : ((m_cnt[ub] > 0) ? m_cnt[ub] - 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (dut_out() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_out(), 8'h00);
        end
        reset_n = 1;
    endtask

    task automatic test_first_lookup();
        lookup_valid = 1; lookup_pc = 32'h100; lookup_is_br = 1;
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL first_lookup: got %h expected %h", dut_out(), {1'b1, 1'b0, 6'd0});
        end
    endtask

    task automatic test_train();
        idle_inputs();
        upd_valid = 1; upd_pc = 32'h100; upd_ghr = '0; upd_taken = 1;
        repeat (2) tick();
        idle_inputs();
        lookup_valid = 1; lookup_pc = 32'h100; lookup_is_br = 1;
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b1, 6'd0}) begin
            miscompares++;
            $display("FAIL train_taken: got %h expected %h", dut_out(), {1'b1, 1'b1, 6'd0});
        end
        lookup_pc = '0; lookup_is_br = 0;
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b0, 6'd1}) begin
            miscompares++;
            $display("FAIL train_ghr: got %h expected %h", dut_out(), {1'b1, 1'b0, 6'd1});
        end
    endtask

    task automatic test_saturate();
        bit dir  [6] = '{0, 0, 0, 0, 1, 1};
        bit expt [6] = '{1, 0, 0, 0, 0, 1};
        for (int s = 0; s < 6; s++) begin
            idle_inputs();
            upd_valid = 1; upd_pc = 32'h100; upd_ghr = '0; upd_taken = dir[s];
            tick();
            idle_inputs();
            lookup_valid = 1; lookup_is_br = 1; lookup_pc = PC_W'(m_ghr << 2);
            tick();
            vectors++;
            if (pred_taken !== expt[s]) begin
                miscompares++;
                $display("FAIL saturate_step%0d: got %b expected %b", s, pred_taken, expt[s]);
            end
        end
    endtask

    task automatic test_mispred();
        idle_inputs();
        lookup_valid = 1; lookup_is_br = 1; lookup_pc = $urandom;
        upd_valid = 1; upd_mispred = 1; upd_ghr = 6'b000011; upd_taken = 1; upd_pc = 32'h200;
        tick();
        vectors++;
        if (pred_valid !== 1'b0 || dut_out() !== m_out()) begin
            miscompares++;
            $display("FAIL mispred_squash: got %h expected pred_valid 0, %h", dut_out(), m_out());
        end
        idle_inputs();
        lookup_valid = 1; lookup_pc = '0;
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b0, 6'b000111}) begin
            miscompares++;
            $display("FAIL mispred_ghr: got %h expected %h", dut_out(), {1'b1, 1'b0, 6'b000111});
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        stall = 1; lookup_valid = 1; lookup_is_br = 1; lookup_pc = $urandom;
        upd_valid = 1; upd_taken = 1; upd_pc = 32'(20 << 2); upd_ghr = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (dut_out() !== {1'b1, 1'b0, 6'd7}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %h expected %h", c, dut_out(), {1'b1, 1'b0, 6'd7});
            end
        end
        idle_inputs();
        lookup_valid = 1; lookup_is_br = 1; lookup_pc = 32'((7 ^ 20) << 2);
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b1, 6'd7}) begin
            miscompares++;
            $display("FAIL stall_update: got %h expected %h", dut_out(), {1'b1, 1'b1, 6'd7});
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        upd_valid = 1; upd_taken = 1; upd_pc = 32'h100; upd_ghr = '0;
        lookup_valid = 1; lookup_is_br = 1; lookup_pc = 32'h100;
        #2 reset_n = 0;
        #1;
        vectors++;
        if (dut_out() !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", dut_out(), 8'h00);
        end
        model_reset();
        @(negedge clk);
        tick();
        reset_n = 1;
        idle_inputs();
        lookup_valid = 1; lookup_is_br = 1; lookup_pc = 32'h100;
        tick();
        vectors++;
        if (dut_out() !== {1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL post_reset_lookup: got %h expected %h", dut_out(), {1'b1, 1'b0, 6'd0});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            lookup_valid = ($urandom_range(0, 9) < 8);
            lookup_is_br = ($urandom_range(0, 9) < 6);
            lookup_pc    = $urandom & 32'h0000_01FC;
            stall        = ($urandom_range(0, 9) < 2);
            upd_valid    = ($urandom_range(0, 9) < 5);
            upd_pc       = ($urandom_range(0, 3) == 0) ? lookup_pc : ($urandom & 32'h0000_01FC);
            upd_ghr      = 6'($urandom);
            upd_taken    = $urandom_range(0, 1);
            upd_mispred  = ($urandom_range(0, 9) < 2);
            tick();
            vectors++;
            if (dut_out() !== m_out()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, dut_out(), m_out());
            end
        end
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_lookup();
        test_train();
        test_saturate();
        test_mispred();
        test_stall();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL have parameter: IDX_W, default 6, index width; table depth is 2**IDX_W entries of 2-bit counters.
REQ-002 SHALL have parameter: PC_W, default 32, program counter width.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: lookup_valid  input  1  fetch presents a PC this cycle.
REQ-006 SHALL have port: lookup_pc  input  PC_W  fetch PC.
REQ-007 SHALL have port: lookup_is_br  input  1  predecoded conditional branch at lookup_pc.
REQ-008 SHALL have port: stall  input  1  fetch stalled; lookup ignored, outputs hold.
REQ-009 SHALL have port: pred_valid  output  1  registered prediction valid.
REQ-010 SHALL have port: pred_taken  output  1  predicted direction.
REQ-011 SHALL have port: pred_ghr  output  IDX_W  history snapshot used to form the lookup index; travels with the branch.
REQ-012 SHALL have port: upd_valid  input  1  resolved branch update from commit.
REQ-013 SHALL have port: upd_pc  input  PC_W  PC of resolved branch.
REQ-014 SHALL have port: upd_ghr  input  IDX_W  pred_ghr captured at that branch's prediction.
REQ-015 SHALL have port: upd_taken  input  1  actual direction.
REQ-016 SHALL have port: upd_mispred  input  1  prediction was wrong; qualifies with upd_valid.

Function
REQ-017 SHALL form lookup index = lookup_pc[IDX_W+1:2] XOR ghr, where ghr is the internal IDX_W-bit speculative global history.
REQ-018 SHALL form update index = upd_pc[IDX_W+1:2] XOR upd_ghr.
REQ-019 SHALL, on lookup_valid=1 and stall=0, register next cycle: pred_valid=1; pred_taken=counter[1] if lookup_is_br else 0; pred_ghr=ghr value used for the index (1-cycle latency).
REQ-020 SHALL, on lookup_valid=0 and stall=0, drive pred_valid=0 next cycle; pred_taken and pred_ghr hold.
REQ-021 SHALL, while stall=1, hold pred_valid, pred_taken, pred_ghr, and ghr unchanged (upd path still active).
REQ-022 SHALL, on lookup_valid=1, lookup_is_br=1, stall=0, shift ghr <= {ghr[IDX_W-2:0], predicted bit}; non-branch lookups leave ghr unchanged.
REQ-023 SHALL, on upd_valid=1, update the indexed counter: taken increments, not-taken decrements, saturating at 2'b11 and 2'b00 (states N=00, n=01, t=10, T=11); all other entries unchanged.
REQ-024 SHALL, on upd_valid=1 and upd_mispred=1, set ghr <= {upd_ghr[IDX_W-2:0], upd_taken}, overriding any same-cycle speculative shift, and drive pred_valid=0 next cycle regardless of lookup_valid or stall.
REQ-025 SHALL ignore upd_mispred when upd_valid=0.
REQ-026 SHALL, when lookup and update hit the same entry in one cycle, return the pre-update counter value; the update is visible to lookups from the next cycle.
REQ-027 SHALL keep only one update port; at most one counter changes per cycle.
REQ-028 SHALL produce no combinational path from any input to any output.

Reset
REQ-029 SHALL, while reset_n=0, immediately and asynchronously set every counter to 2'b01, ghr=0, pred_valid=0, pred_taken=0, pred_ghr=0.
REQ-030 SHALL ignore lookup and update inputs while reset_n=0, including an update in flight at reset assertion.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Verification
REQ-032 SHALL cover: after reset, lookup pc=0x100 branch -> next cycle pred_valid=1, pred_taken=0, pred_ghr=0; ghr becomes 0.
REQ-033 SHALL cover: two upd_valid taken, upd_pc=0x100, upd_ghr=0 -> counter 01->10->11; lookup pc=0x100 with ghr=0 -> pred_taken=1, ghr becomes 000001.
REQ-034 SHALL cover: four not-taken updates from 11 -> 10,01,00,00 (saturates); fifth taken -> 01.
REQ-035 SHALL cover: same-cycle lookup branch and upd_mispred=1, upd_ghr=6'b000011, upd_taken=1 -> ghr=6'b000111, next-cycle pred_valid=0.
REQ-036 SHALL cover: stall=1 for 3 cycles with lookup_valid=1 -> outputs and ghr frozen; update during stall still applied to the counter.
REQ-037 SHALL cover: reset_n pulsed low mid-cycle after training -> all outputs 0 without clock edge; following lookup pc=0x100 returns pred_taken=0.
